// File: rtl/id_ex_stage_if.sv
// Pipeline stage bundle: one instruction slot between two stages.
// master drives the slot, slave consumes it.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              valid;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;

    modport master (
        output valid, opcode, rs, rt, rd,
        output rs_data, rt_data, imm, pc4
    );

    modport slave (
        input valid, opcode, rs, rt, rd,
        input rs_data, rt_data, imm, pc4
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// flush handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     id,
    id_ex_stage_if.master    ex,
    input  logic             flush,
    output logic             stall,
    output logic [7:0]       bubble_cnt
);
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    logic id_uses_rt;
    logic hazard;

    always_comb begin
        id_uses_rt = 1'b0;
        unique case (1'b1)
            (id.opcode == OP_R),
            (id.opcode == OP_SW),
            (id.opcode == OP_BEQ): id_uses_rt = 1'b1;
            default:               id_uses_rt = 1'b0;
        endcase
    end

    always_comb begin
        hazard = ex.valid && (ex.opcode == OP_LW) &&
                 (ex.rt != '0) && id.valid &&
                 ((id.rs == ex.rt) ||
                  (id_uses_rt && (id.rt == ex.rt)));
    end

    assign stall = hazard && !flush;

    // A bubble clears ex_opcode, so a held load-use pair stalls once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex.valid   <= 1'b0;
            ex.opcode  <= '0;
            ex.rs      <= '0;
            ex.rt      <= '0;
            ex.rd      <= '0;
            ex.rs_data <= '0;
            ex.rt_data <= '0;
            ex.imm     <= '0;
            ex.pc4     <= '0;
            bubble_cnt <= '0;
        end else if (flush || hazard || !id.valid) begin
            ex.valid   <= 1'b0;
            ex.opcode  <= '0;
            ex.rs      <= '0;
            ex.rt      <= '0;
            ex.rd      <= '0;
            ex.rs_data <= '0;
            ex.rt_data <= '0;
            ex.imm     <= '0;
            ex.pc4     <= '0;
            if (!flush && hazard && (bubble_cnt != 8'hff)) begin
                bubble_cnt <= bubble_cnt + 8'd1;
            end
        end else begin
            ex.valid   <= 1'b1;
            ex.opcode  <= id.opcode;
            ex.rs      <= id.rs;
            ex.rt      <= id.rt;
            ex.rd      <= id.rd;
            ex.rs_data <= id.rs_data;
            ex.rt_data <= id.rt_data;
            ex.imm     <= id.imm;
            ex.pc4     <= id.pc4;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random bench for id_ex_stage against
// a slot-level reference model.
module tb_id_ex_stage;
    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [7:0] bubble_cnt;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) idb ();
    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) exb ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id         (idb),
        .ex         (exb),
        .flush      (flush),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    slot_t m_ex;
    int    m_cnt;
    bit    m_stall;

    function automatic slot_t id_slot();
        slot_t s;
        s.v   = idb.valid;
        s.op  = idb.opcode;
        s.rs  = idb.rs;
        s.rt  = idb.rt;
        s.rd  = idb.rd;
        s.a   = idb.rs_data;
        s.b   = idb.rt_data;
        s.imm = idb.imm;
        s.pc4 = idb.pc4;
        return s;
    endfunction

    function automatic slot_t ex_obs();
        return {exb.valid, exb.opcode, exb.rs, exb.rt, exb.rd,
                exb.rs_data, exb.rt_data, exb.imm, exb.pc4};
    endfunction

    // Load-use rule evaluated on whole instruction slots.
    function automatic bit load_use(slot_t e, slot_t d);
        bit reads_rt;
        reads_rt = (d.op == 6'h00) || (d.op == 6'h2b) ||
                   (d.op == 6'h04);
        if (!(e.v && e.op == 6'h23 && e.rt != 0 && d.v)) return 0;
        return (d.rs == e.rt) || (reads_rt && d.rt == e.rt);
    endfunction

    task automatic chk(string tag, logic [149:0] obs,
                       logic [149:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(bit v, logic [5:0] op, logic [4:0] rs,
                          logic [4:0] rt, logic [4:0] rd);
        idb.valid   = v;
        idb.opcode  = op;
        idb.rs      = rs;
        idb.rt      = rt;
        idb.rd      = rd;
        idb.rs_data = $urandom;
        idb.rt_data = $urandom;
        idb.imm     = $urandom;
        idb.pc4     = $urandom;
    endtask

    // One clock: check stall, predict, clock, check EX slot.
    task automatic cycle(string tag);
        slot_t d;
        bit    hz;
        d  = id_slot();
        hz = load_use(m_ex, d);
        m_stall = hz && !flush;
        #1;
        chk({tag, ".stall"}, 150'(stall), 150'(m_stall));
        if (flush || hz || !d.v) begin
            m_ex = '0;
            if (!flush && hz && m_cnt < 255) m_cnt++;
        end else begin
            m_ex = d;
        end
        @(posedge clk);
        #1;
        chk({tag, ".ex"}, 150'(ex_obs()), 150'(m_ex));
        chk({tag, ".cnt"}, 150'(bubble_cnt), 150'(m_cnt));
        @(negedge clk);
    endtask

    logic [5:0] ops [8];

    initial begin
        ops = '{6'h00, 6'h23, 6'h23, 6'h2b, 6'h04,
                6'h08, 6'h09, 6'h0d};
        set_id(0, 0, 0, 0, 0);
        m_ex = '0;
        m_cnt = 0;
        #12;
        chk("reset.ex", 150'(ex_obs()), 150'(0));
        chk("reset.cnt", 150'(bubble_cnt), 150'(0));
        chk("reset.stall", 150'(stall), 150'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: lw rt=5 then add rs=5
        set_id(1, 6'h23, 1, 5, 0);
        cycle("lu.lw");
        set_id(1, 6'h00, 5, 2, 3);
        cycle("lu.bubble");
        chk("lu.stall1", 150'(m_stall), 150'(1));
        cycle("lu.add");
        chk("lu.ex_rs", 150'(exb.rs), 150'(5));
        chk("lu.cnt1", 150'(bubble_cnt), 150'(1));

        // No hazard: addi does not read rt
        set_id(1, 6'h23, 1, 5, 0);
        cycle("nh.lw");
        set_id(1, 6'h08, 3, 5, 0);
        cycle("nh.addi");
        chk("nh.op", 150'(exb.opcode), 150'(6'h08));

        // Flush beats hazard
        set_id(1, 6'h23, 1, 5, 0);
        cycle("fl.lw");
        set_id(1, 6'h00, 5, 5, 4);
        flush = 1'b1;
        cycle("fl.flush");
        flush = 1'b0;
        chk("fl.valid", 150'(exb.valid), 150'(0));

        // Zero register never raises hazard
        set_id(1, 6'h23, 1, 0, 0);
        cycle("zr.lw");
        set_id(1, 6'h2b, 0, 0, 0);
        cycle("zr.sw");
        chk("zr.op", 150'(exb.opcode), 150'(6'h2b));

        // Async reset mid-cycle with EX valid
        set_id(1, 6'h09, 2, 3, 4);
        cycle("ar.fill");
        #3;
        rst_n = 1'b0;
        #1;
        m_ex = '0;
        m_cnt = 0;
        chk("ar.ex", 150'(ex_obs()), 150'(0));
        chk("ar.cnt", 150'(bubble_cnt), 150'(0));
        chk("ar.stall", 150'(stall), 150'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1, 6'h0d, 7, 8, 9);
        cycle("ar.resume");

        // Saturation after 260 load-use events
        for (int i = 0; i < 260; i++) begin
            set_id(1, 6'h23, 1, 6, 0);
            cycle("sat.lw");
            set_id(1, 6'h04, 2, 6, 0);
            cycle("sat.bub");
            cycle("sat.use");
        end
        chk("sat.cnt", 150'(bubble_cnt), 150'(255));

        // Random traffic, ID held while stalled
        rst_n = 1'b0;
        #1;
        m_ex = '0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        m_stall = 0;
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 7) == 0);
            if (!m_stall) begin
                set_id($urandom_range(0, 5) != 0,
                       ops[$urandom_range(0, 7)],
                       5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 31)));
            end
            cycle("rnd");
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
